// File: rtl/cond_logic.sv
// Conditional-execution stage: holds the architectural N,Z,C,V flags, evaluates
// the instruction condition against them and gates the decoder's side effects.
module cond_logic #(
  parameter logic [3:0] FLAG_RST = 4'b0000,
  parameter bit         NV_EXEC  = 1'b0
) (
  input  logic       CLK,
  input  logic       Reset_n,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       Stall,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags
);

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  logic [1:0] nz_q, nz_d;
  logic [1:0] cv_q, cv_d;
  logic       n, z, c, v;
  logic       cond_ex;
  logic       exec;

  assign {n, z} = nz_q;
  assign {c, v} = cv_q;

  always_comb begin
    cond_ex = 1'b0;
    case (cond_e'(Cond))
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = NV_EXEC;
    endcase
  end

  // Reset_n in the qualifier drops all side effects combinationally while reset is held.
  assign exec     = cond_ex & ~Stall & Reset_n;
  assign CondEx   = cond_ex;
  assign PCSrc    = PCS  & exec;
  assign RegWrite = RegW & exec;
  assign MemWrite = MemW & exec;

  always_comb begin
    nz_d = nz_q;
    cv_d = cv_q;
    if (FlagW[1] && exec) nz_d = ALUFlags[3:2];
    if (FlagW[0] && exec) cv_d = ALUFlags[1:0];
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      nz_q <= FLAG_RST[3:2];
      cv_q <= FLAG_RST[1:0];
    end else begin
      nz_q <= nz_d;
      cv_q <= cv_d;
    end
  end

  assign Flags = {nz_q, cv_q};

endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
- Conditional-execution stage directly downstream of the instruction decoder in the single-cycle ARM core.
- Holds the architectural N, Z, C and V flag registers.
- Evaluates the instruction's 4-bit condition field against the held flags.
- Gates the decoder's write-enable and PC-select requests so that only instructions whose condition passes have side effects.
- Updates the flags from the ALU under the decoder's two-bit flag-write mask.

Parameters:
- FLAG_RST, 4'b0000: reset value of {N,Z,C,V}.
- NV_EXEC, 0: behaviour for cond 4'b1111. 0 = never execute; 1 = execute always.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset. Clock is CLK; reset is asynchronous active-low.
- Cond  in  4  Instr[31:28].
- ALUFlags  in  4  {N,Z,C,V} produced by the ALU this cycle.
- FlagW  in  2  from decoder. [1] requests N,Z update; [0] requests C,V update.
- PCS  in  1  decoder PC-write request (branch or Rd==15 write).
- RegW  in  1  decoder register-write request.
- MemW  in  1  decoder memory-write request.
- Stall  in  1  core stall, e.g. a multi-cycle unit is busy.
- PCSrc  out  1  gated PC select.
- RegWrite  out  1  gated register-file write enable.
- MemWrite  out  1  gated data-memory write enable.
- CondEx  out  1  condition-passed indicator.
- Flags  out  4  current registered {N,Z,C,V}; the ALU uses C as its carry-in.

Behaviour:

Flag state:
- Two registers: NZ[1:0] and CV[1:0].
- Reset_n low immediately forces {NZ,CV} = FLAG_RST, independent of CLK.
- Flags output equals the registers at all times, so it is FLAG_RST during reset.

Condition evaluation:
- CondEx is combinational from Cond and the registered flags only. It never uses the same-cycle ALUFlags.
- Codes:
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C&~Z
  - 1001 LS: ~C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: NV_EXEC
- No X propagation: the case is fully specified.

Output gating (combinational, zero latency):
- PCSrc = PCS & CondEx & ~Stall
- RegWrite = RegW & CondEx & ~Stall
- MemWrite = MemW & CondEx & ~Stall
- During reset all three are forced to 0, regardless of their inputs.

Flag update (rising CLK, Reset_n high):
- If FlagW[1] & CondEx & ~Stall: NZ <= ALUFlags[3:2].
- If FlagW[0] & CondEx & ~Stall: CV <= ALUFlags[1:0].
- The two halves update independently. FlagW=2'b10 leaves C,V unchanged.
- A failed condition or an asserted Stall holds both halves.
- Latency: new flags are visible on Flags and in CondEx in the cycle after the flag-setting instruction. Back-to-back CMP then BEQ therefore works with no bubble.

Boundary cases:
- Stall for N cycles then release: flags update exactly once, on the release edge, if the condition still passes.
- Reset asserted mid-cycle: flags revert immediately and the outputs drop the same cycle.
- Reset deassertion is synchronised externally; no update occurs on a clock edge where Reset_n is low.
- Simultaneous RegW, MemW and PCS are gated identically; there is no priority between them.

Test Plan:
1. Reset with FLAG_RST=0: pulse Reset_n low mid-cycle -> Flags=0000 immediately and PCSrc/RegWrite/MemWrite=0. Then Cond=0000 (EQ) with RegW=1 -> RegWrite=0.
2. CMP-equal then BEQ: cycle 0 has Cond=1110, FlagW=11, ALUFlags=0110 -> after the edge Flags=0110. Cycle 1 has Cond=0000, PCS=1 -> PCSrc=1. A following Cond=0001 with PCS=1 -> PCSrc=0.
3. Partial flag write: Flags=1111, then FlagW=10 with ALUFlags=0000 -> Flags=0011. Then FlagW=01 with ALUFlags=0000 -> Flags=0000.
4. Failed condition blocks flag write: Flags=0000, Cond=0000 (EQ fails), FlagW=11, ALUFlags=1111, MemW=1 -> MemWrite=0 and Flags remains 0000 after the edge.
5. Signed compares: sweep all 16 Flags values × Cond 1010..1101 -> CondEx matches the table. Specifically N=1,V=0,Z=0 gives GE=0, LT=1, GT=0, LE=1.
6. Stall: Stall=1 for 3 cycles with Cond=1110, RegW=1, FlagW=11, ALUFlags=1000 -> RegWrite=0 and Flags unchanged throughout. On the release cycle RegWrite=1, and after that edge Flags=1000.
